multicycle_ctrl: RTL and testbench

//  Parametrised multicycle control unit for the 16-bit datapath: fetch/decode/execute FSM driving PC, IR, data memory,

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute control unit for the 16-bit datapath.
// Only the state and the sticky illegal flag are stored; all strobes decode from state and IR.
module multicycle_ctrl #(
    parameter int IR_W   = 16,
    parameter int OP_W   = 4,
    parameter int RF_AW  = 4,
    parameter int D_AW   = 8,
    parameter int PC_W   = 8,
    parameter int ALU_SW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   ir,
    input  logic [PC_W-1:0]   pc,
    input  logic              alu_z,
    input  logic              d_rdy,
    input  logic              resume,
    output logic              pc_clr,
    output logic              pc_ic,
    output logic              pc_ld,
    output logic [PC_W-1:0]   pc_tgt,
    output logic              ir_ld,
    output logic [D_AW-1:0]   d_addr,
    output logic              d_rd,
    output logic              d_wr,
    output logic              rf_s,
    output logic              rf_w_en,
    output logic [RF_AW-1:0]  rf_a_addr,
    output logic [RF_AW-1:0]  rf_b_addr,
    output logic [RF_AW-1:0]  rf_w_addr,
    output logic [ALU_SW-1:0] alu_s,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_ALU    = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_STORE  = 4'd7,
        S_JMP    = 4'd8,
        S_BR     = 4'd9,
        S_HALT   = 4'd10,
        S_ILL    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(8);

    localparam logic [ALU_SW-1:0] ALU_ADD = ALU_SW'(1);
    localparam logic [ALU_SW-1:0] ALU_SUB = ALU_SW'(2);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [OP_W-1:0]  opcode;
    logic [RF_AW-1:0] rd, rb, ra, st_src;
    logic [D_AW-1:0]  ld_addr, st_addr;
    logic [PC_W-1:0]  jmp_tgt, br_off;
    logic             br_taken;

    assign opcode   = ir[IR_W-1 -: OP_W];
    assign rd       = ir[RF_AW-1:0];
    assign rb       = ir[2*RF_AW-1:RF_AW];
    assign ra       = ir[3*RF_AW-1:2*RF_AW];
    assign ld_addr  = ir[D_AW+RF_AW-1:RF_AW];
    assign st_addr  = ir[D_AW-1:0];
    assign st_src   = ir[D_AW+RF_AW-1:D_AW];
    assign jmp_tgt  = ir[PC_W-1:0];
    assign br_off   = {{(PC_W-RF_AW){ir[RF_AW-1]}}, ir[RF_AW-1:0]};
    assign br_taken = (opcode == OP_BEQ) ? alu_z : ~alu_z;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:        state_d = S_NOOP;
                    OP_LOAD:        state_d = S_LOAD_A;
                    OP_STORE:       state_d = S_STORE;
                    OP_ADD, OP_SUB: state_d = S_ALU;
                    OP_HALT:        state_d = S_HALT;
                    OP_JMP:         state_d = S_JMP;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    default: begin
                        state_d   = S_ILL;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_LOAD_A: if (d_rdy) state_d = S_LOAD_B;
            S_HALT:   if (resume) state_d = S_FETCH;
            // The trap is terminal: only reset leaves it.
            S_ILL:    state_d = S_ILL;
            S_NOOP, S_ALU, S_LOAD_B, S_STORE, S_JMP, S_BR: state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_clr    = 1'b0;
        pc_ic     = 1'b0;
        pc_ld     = 1'b0;
        pc_tgt    = '0;
        ir_ld     = 1'b0;
        d_addr    = '0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        rf_s      = 1'b0;
        rf_w_en   = 1'b0;
        rf_a_addr = '0;
        rf_b_addr = '0;
        rf_w_addr = '0;
        alu_s     = '0;
        halted    = 1'b0;
        case (state_q)
            S_INIT:   pc_clr = 1'b1;
            S_FETCH:  ir_ld  = 1'b1;
            S_DECODE: pc_ic  = 1'b1;
            S_ALU: begin
                rf_a_addr = ra;
                rf_b_addr = rb;
                rf_w_addr = rd;
                alu_s     = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                rf_w_en   = 1'b1;
            end
            // Read strobe and write-back address are held for every wait cycle.
            S_LOAD_A: begin
                d_addr    = ld_addr;
                d_rd      = 1'b1;
                rf_w_addr = rd;
                rf_s      = 1'b1;
            end
            S_LOAD_B: begin
                d_addr    = ld_addr;
                rf_s      = 1'b1;
                rf_w_en   = 1'b1;
                rf_w_addr = rd;
            end
            S_STORE: begin
                d_addr    = st_addr;
                rf_a_addr = st_src;
                d_wr      = 1'b1;
            end
            S_JMP: begin
                pc_ld  = 1'b1;
                pc_tgt = jmp_tgt;
            end
            S_BR: begin
                rf_a_addr = ra;
                rf_b_addr = rb;
                alu_s     = ALU_SUB;
                if (br_taken) begin
                    pc_ld  = 1'b1;
                    pc_tgt = pc + br_off;
                end
            end
            S_HALT, S_ILL: halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level schedule model expands each instruction
// into per-cycle expected outputs; one negedge process compares them against the DUT.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_ic;
        logic       pc_ld;
        logic [7:0] pc_tgt;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [3:0] rf_a;
        logic [3:0] rf_b;
        logic [3:0] rf_w;
        logic [3:0] alu_s;
        logic       halted;
        logic       illegal;
    } out_t;

    localparam int OUT_W = $bits(out_t);

    logic        clk;
    logic        rst_n;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        alu_z;
    logic        d_rdy;
    logic        resume;
    logic        pc_clr, pc_ic, pc_ld, ir_ld, d_rd, d_wr, rf_s, rf_w_en, halted, illegal;
    logic [7:0]  pc_tgt, d_addr;
    logic [3:0]  rf_a_addr, rf_b_addr, rf_w_addr, alu_s, dbg_state;

    logic [OUT_W-1:0] act;
    logic [OUT_W-1:0] exp_q[$];
    logic             ill_m;
    int               n_checks;
    int               n_pass;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .pc(pc), .alu_z(alu_z), .d_rdy(d_rdy),
        .resume(resume), .pc_clr(pc_clr), .pc_ic(pc_ic), .pc_ld(pc_ld), .pc_tgt(pc_tgt),
        .ir_ld(ir_ld), .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_s(rf_s),
        .rf_w_en(rf_w_en), .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
        .rf_w_addr(rf_w_addr), .alu_s(alu_s), .halted(halted), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    assign act = {pc_clr, pc_ic, pc_ld, pc_tgt, ir_ld, d_addr, d_rd, d_wr, rf_s, rf_w_en,
                  rf_a_addr, rf_b_addr, rf_w_addr, alu_s, halted, illegal};

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timed out");
    end

    // Scoreboard: one expected vector per cycle, checked at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [OUT_W-1:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL out_vec t=%0t state=%0d got=%h want=%h", $time, dbg_state, act, e);
        end
    end

    function automatic out_t blank();
        out_t o;
        o = '0;
        o.illegal = ill_m;
        return o;
    endfunction

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    task automatic drive(input out_t e, input logic rdy, input logic res);
        d_rdy  = rdy;
        resume = res;
        exp_q.push_back(e);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_t o;
        rst_n = 1'b0;
        ill_m = 1'b0;
        o = blank();
        o.pc_clr = 1'b1;
        drive(o, 1'b1, 1'b0);
        pin("rst_illegal", illegal, 0);
        pin("rst_pc_clr", pc_clr, 1);
        tick();
        drive(o, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(o, 1'b1, 1'b0);
        tick();
    endtask

    // Expand one instruction into its cycle schedule; n = wait cycles, hold cycles or trap cycles
    task automatic run_instr(input logic [15:0] i, input logic [7:0] p, input logic z, input int n);
        out_t       o;
        logic [3:0] op;
        int         cnt;
        int         off;
        logic       taken;
        op    = i[15:12];
        ir    = i;
        pc    = p;
        alu_z = z;
        o = blank();
        o.ir_ld = 1'b1;
        drive(o, 1'b1, 1'b0);
        if (i == 16'h3126) pin("fetch_ir_ld", ir_ld, 1);
        tick();
        o = blank();
        o.pc_ic = 1'b1;
        drive(o, 1'b1, 1'b0);
        if (i == 16'h3126) pin("decode_pc_ic", pc_ic, 1);
        tick();
        o = blank();
        case (op)
            4'h0: begin
                drive(o, 1'b1, 1'b0);
                tick();
            end
            4'h1: begin
                o.d_addr = i[11:4];
                o.d_rd   = 1'b1;
                o.rf_s   = 1'b1;
                o.rf_w   = i[3:0];
                cnt = 0;
                for (int k = 0; k <= n; k++) begin
                    drive(o, (k == n), 1'b0);
                    cnt += int'(d_rd);
                    tick();
                end
                o.d_rd    = 1'b0;
                o.rf_w_en = 1'b1;
                drive(o, 1'b1, 1'b0);
                if (i == 16'h1A53) begin
                    pin("load_rd_cycles", cnt, 3);
                    pin("load_b_waddr", rf_w_addr, 3);
                    pin("load_b_wen", rf_w_en, 1);
                    pin("load_b_rf_s", rf_s, 1);
                end
                tick();
            end
            4'h2: begin
                o.d_addr = i[7:0];
                o.rf_a   = i[11:8];
                o.d_wr   = 1'b1;
                drive(o, 1'b1, 1'b0);
                if (i == 16'h2740) begin
                    pin("store_d_wr", d_wr, 1);
                    pin("store_d_addr", d_addr, 8'h40);
                    pin("store_src", rf_a_addr, 7);
                end
                tick();
            end
            4'h3, 4'h4: begin
                o.rf_a    = i[11:8];
                o.rf_b    = i[7:4];
                o.rf_w    = i[3:0];
                o.alu_s   = (op == 4'h3) ? 4'd1 : 4'd2;
                o.rf_w_en = 1'b1;
                drive(o, 1'b1, 1'b0);
                if (i == 16'h3126) begin
                    pin("add_a", rf_a_addr, 1);
                    pin("add_b", rf_b_addr, 2);
                    pin("add_w", rf_w_addr, 6);
                    pin("add_alu_s", alu_s, 1);
                    pin("add_w_en", rf_w_en, 1);
                end
                tick();
            end
            4'h5: begin
                o.halted = 1'b1;
                cnt = 0;
                for (int k = 0; k < n; k++) begin
                    drive(o, 1'b1, 1'b0);
                    cnt += int'(halted);
                    tick();
                end
                drive(o, 1'b1, 1'b1);
                if (i == 16'h5000) pin("halt_held", cnt, 10);
                tick();
                resume = 1'b0;
            end
            4'h6: begin
                o.pc_ld  = 1'b1;
                o.pc_tgt = i[7:0];
                drive(o, 1'b1, 1'b0);
                if (i == 16'h60F3) begin
                    pin("jmp_pc_ld", pc_ld, 1);
                    pin("jmp_tgt", pc_tgt, 8'hF3);
                end
                tick();
            end
            4'h7, 4'h8: begin
                off   = i[3] ? int'(i[3:0]) - 16 : int'(i[3:0]);
                taken = (op == 4'h7) ? z : !z;
                o.rf_a  = i[11:8];
                o.rf_b  = i[7:4];
                o.alu_s = 4'd2;
                if (taken) begin
                    o.pc_ld  = 1'b1;
                    o.pc_tgt = 8'(int'(p) + off);
                end
                drive(o, 1'b1, 1'b0);
                if (i[11:0] == 12'h12E && p == 8'h10) begin
                    pin("br_pc_ld", pc_ld, taken);
                    if (taken) pin("br_tgt", pc_tgt, 8'h0E);
                end
                tick();
            end
            default: begin
                ill_m    = 1'b1;
                o        = blank();
                o.halted = 1'b1;
                for (int k = 0; k < n; k++) begin
                    drive(o, 1'b1, k[0]);
                    tick();
                end
                pin("ill_flag", illegal, 1);
                pin("ill_halted", halted, 1);
                resume = 1'b0;
            end
        endcase
    endtask

    task automatic load_abort(input logic [15:0] i);
        out_t o;
        ir = i;
        o = blank();
        o.ir_ld = 1'b1;
        drive(o, 1'b1, 1'b0);
        tick();
        o = blank();
        o.pc_ic = 1'b1;
        drive(o, 1'b1, 1'b0);
        tick();
        o = blank();
        o.d_addr = i[11:4];
        o.d_rd   = 1'b1;
        o.rf_s   = 1'b1;
        o.rf_w   = i[3:0];
        drive(o, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        ill_m = 1'b0;
        o = blank();
        o.pc_clr = 1'b1;
        drive(o, 1'b0, 1'b0);
        pin("abort_d_rd", d_rd, 0);
        pin("abort_pc_clr", pc_clr, 1);
        tick();
        rst_n = 1'b1;
        drive(o, 1'b1, 1'b0);
        tick();
    endtask

    // Directed program
    initial begin
        n_checks = 0;
        n_pass   = 0;
        ill_m    = 1'b0;
        rst_n    = 1'b0;
        ir       = '0;
        pc       = '0;
        alu_z    = 1'b0;
        d_rdy    = 1'b1;
        resume   = 1'b0;
        tick();
        do_reset();
        run_instr(16'h3126, 8'h01, 1'b0, 0);
        run_instr(16'h4A5C, 8'h02, 1'b1, 0);
        run_instr(16'h1A53, 8'h03, 1'b0, 2);
        run_instr(16'h1234, 8'h04, 1'b0, 0);
        run_instr(16'h2740, 8'h05, 1'b0, 0);
        run_instr(16'h60F3, 8'h06, 1'b0, 0);
        run_instr(16'h712E, 8'h10, 1'b1, 0);
        run_instr(16'h712E, 8'h10, 1'b0, 0);
        run_instr(16'h812E, 8'h10, 1'b1, 0);
        run_instr(16'h812E, 8'h10, 1'b0, 0);
        run_instr(16'h7125, 8'hFE, 1'b1, 0);
        run_instr(16'h8397, 8'h02, 1'b0, 0);
        run_instr(16'h0000, 8'h20, 1'b0, 0);
        run_instr(16'h5000, 8'h21, 1'b0, 10);
        run_instr(16'h0000, 8'h22, 1'b0, 0);
        run_instr(16'hF000, 8'h23, 1'b0, 6);
        do_reset();
        run_instr(16'h9ABC, 8'h00, 1'b0, 3);
        do_reset();
        load_abort(16'h1A53);
        run_instr(16'h3126, 8'h01, 1'b0, 0);
        @(negedge clk);
        #1;
        pin("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
